// File: rtl/acc_unit_pkg.sv
// acc_unit_pkg: opcodes, flag bit positions and FSM states shared by the accumulator unit.
package acc_unit_pkg;
   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_LOAD = 3'd1,
      OP_ADD  = 3'd2,
      OP_SUB  = 3'd3,
      OP_AND  = 3'd4,
      OP_OR   = 3'd5,
      OP_SHL  = 3'd6,
      OP_MUL  = 3'd7
   } op_e;
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;
   typedef enum logic {ST_IDLE, ST_MUL} state_e;
endpackage

// File: rtl/acc_unit_if.sv
// acc_unit_if: operation request / accumulator status bundle; master issues ops, slave is the unit.
interface acc_unit_if import acc_unit_pkg::*; #(parameter int WIDTH = 8);
   logic             op_valid;
   logic             op_ready;
   op_e              op;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] acc_out;
   logic [3:0]       flags;
   logic             busy;
   logic             done;
   modport master (output op_valid, op, operand, input op_ready, acc_out, flags, busy, done);
   modport slave  (input op_valid, op, operand, output op_ready, acc_out, flags, busy, done);
endinterface

// File: rtl/acc_unit_alu.sv
// acc_alu: combinational result and {V,C,N,Z} for single-cycle ops; NOP and MUL pass acc and flags through.
module acc_alu import acc_unit_pkg::*; #(parameter int WIDTH = 8) (
   input  op_e              op,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] operand,
   input  logic [3:0]       flags_in,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags_out
);
   localparam int M = WIDTH - 1;
   logic [WIDTH:0] sum, dif;
   logic c, v;
   always_comb begin
      sum = {1'b0, acc} + {1'b0, operand};
      dif = {1'b0, acc} - {1'b0, operand};
      result = acc;
      c = 1'b0;
      v = 1'b0;
      case (op)
         OP_LOAD: result = operand;
         OP_ADD: begin
            result = sum[M:0];
            c = sum[WIDTH];
            v = (acc[M] == operand[M]) && (sum[M] != acc[M]);
         end
         OP_SUB: begin
            result = dif[M:0];
            c = dif[WIDTH];
            v = (acc[M] != operand[M]) && (dif[M] != acc[M]);
         end
         OP_AND: result = acc & operand;
         OP_OR:  result = acc | operand;
         OP_SHL: begin
            result = {acc[M-1:0], 1'b0};
            c = acc[M];
         end
         default: result = acc;
      endcase
      flags_out = flags_in;
      if (op != OP_NOP && op != OP_MUL) begin
         flags_out[FLAG_Z] = result == '0;
         flags_out[FLAG_N] = result[M];
         flags_out[FLAG_C] = c;
         flags_out[FLAG_V] = v;
      end
   end
endmodule

// File: rtl/acc_unit.sv
// acc_unit: accumulator with single-cycle ALU ops and an optional shift-add multiplier.
// Define ACC_UNIT_MUL_EN to build the MUL opcode; otherwise op 7 acts as NOP and the unit is never busy.
module acc_unit import acc_unit_pkg::*; #(parameter int WIDTH = 8) (
   input logic        clk,
   input logic        reset,
   acc_unit_if.slave  bus
);
   logic [WIDTH-1:0] acc, alu_res, mul_acc;
   logic [3:0] flags, alu_flags, mul_flags;
   logic done, busy, accept, is_mul, mul_last;
   op_e op;
   assign op = bus.op;
   assign accept = bus.op_valid && !busy;
   assign bus.op_ready = !busy;
   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.acc_out = acc;
   assign bus.flags = flags;
   acc_alu #(.WIDTH(WIDTH)) u_alu (
      .op(op), .acc(acc), .operand(bus.operand), .flags_in(flags),
      .result(alu_res), .flags_out(alu_flags)
   );
`ifdef ACC_UNIT_MUL_EN
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   state_e state, state_n;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] mplier;
   logic [2*WIDTH-1:0] mcand, prod, prod_n;
   logic mul_start;
   assign busy = state == ST_MUL;
   assign is_mul = op == OP_MUL;
   assign mul_start = accept && is_mul;
   // One multiplier bit per edge: add the multiplicand shifted to that bit's weight.
   assign prod_n = prod + (mplier[cnt] ? mcand << cnt : '0);
   assign mul_acc = prod_n[WIDTH-1:0];
   assign mul_flags = {1'b0, |prod_n[2*WIDTH-1:WIDTH], prod_n[WIDTH-1], ~|prod_n[WIDTH-1:0]};
   always_comb begin
      state_n = state;
      mul_last = 1'b0;
      if (state == ST_IDLE && mul_start) state_n = ST_MUL;
      else if (state == ST_MUL && cnt == CNT_LAST) begin
         state_n = ST_IDLE;
         mul_last = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= ST_IDLE;
         cnt <= '0;
         mcand <= '0;
         mplier <= '0;
         prod <= '0;
      end else begin
         state <= state_n;
         if (mul_start) begin
            mcand <= {{WIDTH{1'b0}}, acc};
            mplier <= bus.operand;
            prod <= '0;
            cnt <= '0;
         end else if (busy) begin
            prod <= prod_n;
            cnt <= cnt + 1'b1;
         end
      end
`else
   assign busy = 1'b0;
   assign is_mul = 1'b0;
   assign mul_last = 1'b0;
   assign mul_acc = '0;
   assign mul_flags = '0;
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         acc <= '0;
         flags <= '0;
         done <= 1'b0;
      end else begin
         done <= (accept && !is_mul) || mul_last;
         if (mul_last) begin
            acc <= mul_acc;
            flags <= mul_flags;
         end else if (accept && !is_mul) begin
            acc <= alu_res;
            flags <= alu_flags;
         end
      end
endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: randomized and directed checks of acc_unit against an arithmetic reference model.
module tb_acc_unit;
   import acc_unit_pkg::*;
   localparam int WIDTH = 8;
   localparam int MOD = 1 << WIDTH;
   localparam int HALF = 1 << (WIDTH - 1);
`ifdef ACC_UNIT_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int failures = 0;
   int m_acc = 0;
   logic [3:0] m_flags = 4'h0;
   acc_unit_if #(.WIDTH(WIDTH)) bus ();
   acc_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic int to_signed(input int x);
      return x >= HALF ? x - MOD : x;
   endfunction
   function automatic void model_apply(input int o, input int d);
      int r, s;
      bit c, v;
      r = m_acc;
      c = 1'b0;
      v = 1'b0;
      if (o == 0 || (o == 7 && !MUL_EN)) return;
      case (o)
         1: r = d;
         2: begin
            r = (m_acc + d) % MOD;
            c = m_acc + d >= MOD;
            s = to_signed(m_acc) + to_signed(d);
            v = s >= HALF || s < -HALF;
         end
         3: begin
            r = (m_acc - d + MOD) % MOD;
            c = m_acc < d;
            s = to_signed(m_acc) - to_signed(d);
            v = s >= HALF || s < -HALF;
         end
         4: r = m_acc & d;
         5: r = m_acc | d;
         6: begin
            r = (m_acc * 2) % MOD;
            c = m_acc >= HALF;
         end
         default: begin
            r = (m_acc * d) % MOD;
            c = m_acc * d >= MOD;
         end
      endcase
      m_acc = r;
      m_flags = {v, c, r >= HALF, r == 0};
   endfunction
   task automatic run_op(input int o, input int d, input bit inject, input bit idle_after);
      logic [WIDTH-1:0] old_acc;
      logic [3:0] old_flags;
      logic [WIDTH-1:0] want_acc;
      old_acc = WIDTH'(m_acc);
      old_flags = m_flags;
      @(negedge clk);
      bus.op_valid = 1'b1;
      bus.op = op_e'(o);
      bus.operand = WIDTH'(d);
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      model_apply(o, d);
      if (MUL_EN && o == 7) begin
         for (int i = 0; i < WIDTH; i++) begin
            checks++;
            if ({bus.busy, bus.op_ready, bus.done, bus.acc_out, bus.flags} !== {1'b1, 1'b0, 1'b0, old_acc, old_flags}) begin
               failures++;
               $display("FAIL mul_busy cyc=%0d got busy=%b rdy=%b done=%b acc=%h flags=%h want busy=1 rdy=0 done=0 acc=%h flags=%h",
                        i, bus.busy, bus.op_ready, bus.done, bus.acc_out, bus.flags, old_acc, old_flags);
            end
            bus.op_valid = inject;
            bus.op = OP_ADD;
            bus.operand = WIDTH'($urandom);
            @(posedge clk);
            #1;
         end
         bus.op_valid = 1'b0;
      end
      want_acc = WIDTH'(m_acc);
      checks++;
      if ({bus.busy, bus.op_ready, bus.done, bus.acc_out, bus.flags} !== {1'b0, 1'b1, 1'b1, want_acc, m_flags}) begin
         failures++;
         $display("FAIL op%0d_result d=%h got busy=%b rdy=%b done=%b acc=%h flags=%h want busy=0 rdy=1 done=1 acc=%h flags=%h",
                  o, d, bus.busy, bus.op_ready, bus.done, bus.acc_out, bus.flags, want_acc, m_flags);
      end
      if (idle_after) begin
         bus.op = op_e'($urandom_range(0, 7));
         bus.operand = WIDTH'($urandom);
         @(posedge clk);
         #1;
         checks++;
         if ({bus.done, bus.busy, bus.acc_out, bus.flags} !== {1'b0, 1'b0, want_acc, m_flags}) begin
            failures++;
            $display("FAIL idle_hold got done=%b busy=%b acc=%h flags=%h want done=0 busy=0 acc=%h flags=%h",
                     bus.done, bus.busy, bus.acc_out, bus.flags, want_acc, m_flags);
         end
      end
   endtask
   task automatic test_reset;
      bus.op_valid = 1'b0;
      bus.op = OP_NOP;
      bus.operand = '0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.acc_out, bus.flags, bus.busy, bus.done, bus.op_ready} !== {8'h00, 4'h0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state got acc=%h flags=%h busy=%b done=%b rdy=%b want 00 0 0 0 1",
                  bus.acc_out, bus.flags, bus.busy, bus.done, bus.op_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      m_acc = 0;
      m_flags = 4'h0;
   endtask
   task automatic directed(input int o1, input int d1, input int o2, input int d2,
                           input logic [7:0] ea, input logic [3:0] ef, input bit inj);
      run_op(o1, d1, 1'b0, 1'b0);
      run_op(o2, d2, inj, 1'b1);
      checks++;
      if ({bus.acc_out, bus.flags} !== {ea, ef}) begin
         failures++;
         $display("FAIL directed op%0d(%h) got acc=%h flags=%h want acc=%h flags=%h",
                  o2, d2, bus.acc_out, bus.flags, ea, ef);
      end
   endtask
   task automatic test_directed;
      directed(1, 8'hCC, 2, 8'h50, 8'h1C, 4'b0100, 1'b0);
      directed(1, 8'h10, 3, 8'h20, 8'hF0, 4'b0110, 1'b0);
      directed(1, 8'h7F, 2, 8'h01, 8'h80, 4'b1010, 1'b0);
      directed(1, 8'h81, 6, 8'h5A, 8'h02, 4'b0100, 1'b0);
      directed(1, 8'h0F, 0, 8'hFF, 8'h0F, 4'b0000, 1'b0);
      directed(1, 8'hF0, 4, 8'h0F, 8'h00, 4'b0001, 1'b0);
`ifdef ACC_UNIT_MUL_EN
      directed(1, 8'h0C, 7, 8'h0B, 8'h84, 4'b0010, 1'b1);
      directed(1, 8'h20, 7, 8'h10, 8'h00, 4'b0101, 1'b0);
`else
      directed(1, 8'h0C, 7, 8'h0B, 8'h0C, 4'b0000, 1'b0);
`endif
   endtask
   task automatic test_random;
      for (int n = 0; n < 120; n++)
         run_op($urandom_range(0, 7), $urandom_range(0, MOD - 1), 1'($urandom), 1'($urandom));
   endtask
   task automatic test_back_to_back;
      int o, d;
      logic [WIDTH-1:0] want;
      for (int n = 0; n < 8; n++) begin
         o = $urandom_range(0, 6);
         d = $urandom_range(0, MOD - 1);
         @(negedge clk);
         bus.op_valid = 1'b1;
         bus.op = op_e'(o);
         bus.operand = WIDTH'(d);
         for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            model_apply(o, d);
            want = WIDTH'(m_acc);
            checks++;
            if ({bus.done, bus.acc_out, bus.flags} !== {1'b1, want, m_flags}) begin
               failures++;
               $display("FAIL b2b op%0d d=%h got done=%b acc=%h flags=%h want done=1 acc=%h flags=%h",
                        o, d, bus.done, bus.acc_out, bus.flags, want, m_flags);
            end
            o = $urandom_range(0, 6);
            d = $urandom_range(0, MOD - 1);
            bus.op = op_e'(o);
            bus.operand = WIDTH'(d);
         end
         bus.op_valid = 1'b0;
         @(posedge clk);
         #1;
         checks++;
         if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_clear got done=%b want 0", bus.done);
         end
      end
   endtask
   task automatic test_reset_mid_op;
      run_op(1, 8'h0C, 1'b0, 1'b0);
      @(negedge clk);
      bus.op_valid = 1'b1;
      bus.op = OP_MUL;
      bus.operand = 8'h0B;
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.acc_out, bus.flags, bus.busy, bus.done, bus.op_ready} !== {8'h00, 4'h0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL async_reset got acc=%h flags=%h busy=%b done=%b rdy=%b want 00 0 0 0 1",
                  bus.acc_out, bus.flags, bus.busy, bus.done, bus.op_ready);
      end
      m_acc = 0;
      m_flags = 4'h0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < WIDTH + 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({bus.done, bus.busy, bus.acc_out} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL abort_quiet cyc=%0d got done=%b busy=%b acc=%h want 0 0 00", i, bus.done, bus.busy, bus.acc_out);
         end
      end
      run_op(1, 8'h55, 1'b0, 1'b1);
      checks++;
      if (bus.acc_out !== 8'h55) begin
         failures++;
         $display("FAIL post_reset_load got acc=%h want 55", bus.acc_out);
      end
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
